// File: rtl/lib_pkg.sv
// lib_pkg: funct3 size/unsigned encodings and FSM state type shared by the alignment unit
package lib_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam int F3_UNS = 2;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
endpackage

// File: rtl/mem_lane_extend.sv
// mem_lane_extend: pulls load bytes out of two beats' lanes and sign/zero-extends them to XLEN
module mem_lane_extend
  import lib_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             d0,
  input  logic [XLEN-1:0]             d1,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [2:0]                  funct3,
  output logic [XLEN-1:0]             rdata
);
  logic [2*XLEN-1:0] raw;
  logic [63:0] s;
  logic sx;
  always_comb begin
    raw = {d1, d0} >> {off, 3'b000};
    s = 64'(raw[XLEN-1:0]);
    sx = ~funct3[F3_UNS];
    rdata = XLEN'(funct3[1:0] == SZ_B ? {{56{sx & s[7]}}, s[7:0]} :
                  funct3[1:0] == SZ_H ? {{48{sx & s[15]}}, s[15:0]} :
                  funct3[1:0] == SZ_W ? {{32{sx & s[31]}}, s[31:0]} : s);
  end
endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit: RISC-V load/store alignment unit, splits or faults accesses that cross a word boundary
module mem_align_unit
  import lib_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter bit SPLIT_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_fault,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  state_t state;
  logic load_q, split_q, rdy_q, rv_q, fault, beat_done;
  logic [2:0] f3_q;
  logic [OW-1:0] off_q;
  logic [NB-1:0] be1_q;
  logic [XLEN-1:0] wd1_q, d0_q, d1_q, d0_n, d1_n, ext;
  logic [2*NB-1:0] msk, be_w;
  logic [2*XLEN-1:0] wd_w;
  assign req_ready = state == IDLE;
  // Double-width shifts: the upper half is what spills into the second beat
  always_comb begin
    msk = req_funct3[1:0] == SZ_B ? (2*NB)'(8'h01) :
          req_funct3[1:0] == SZ_H ? (2*NB)'(8'h03) :
          req_funct3[1:0] == SZ_W ? (2*NB)'(8'h0F) : (2*NB)'(8'hFF);
    be_w = msk << req_addr[OW-1:0];
    wd_w = {{XLEN{1'b0}}, req_wdata} << {req_addr[OW-1:0], 3'b000};
    fault = req_funct3 == 3'b111 ||
            (XLEN == 32 && (req_funct3[1:0] == SZ_D || req_funct3 == 3'b110)) ||
            (!req_load && req_funct3[F3_UNS]) ||
            (!SPLIT_MISALIGNED && |be_w[2*NB-1:NB]);
    d0_n = state == BEAT0 && mem_rvalid ? mem_rdata : d0_q;
    d1_n = state == BEAT1 && mem_rvalid ? mem_rdata : d1_q;
    beat_done = (rdy_q || (mem_valid && mem_ready)) && (!load_q || rv_q || mem_rvalid);
  end
  mem_lane_extend #(.XLEN(XLEN)) u_ext (
    .d0(d0_n), .d1(d1_n), .off(off_q), .funct3(f3_q), .rdata(ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {load_q, split_q, rdy_q, rv_q} <= '0;
      f3_q <= '0;
      off_q <= '0;
      be1_q <= '0;
      wd1_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
      mem_valid <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          load_q <= req_load;
          f3_q <= req_funct3;
          off_q <= req_addr[OW-1:0];
          be1_q <= be_w[2*NB-1:NB];
          wd1_q <= wd_w[2*XLEN-1:XLEN];
          split_q <= |be_w[2*NB-1:NB];
          {rdy_q, rv_q} <= '0;
          d0_q <= '0;
          d1_q <= '0;
          if (fault) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= BEAT0;
            mem_valid <= 1'b1;
            mem_we <= !req_load;
            mem_addr <= req_addr & ~ADDR_W'(NB - 1);
            mem_be <= be_w[NB-1:0];
            mem_wdata <= wd_w[XLEN-1:0];
          end
        end
        BEAT0, BEAT1: begin
          if (mem_valid && mem_ready) begin
            mem_valid <= 1'b0;
            rdy_q <= 1'b1;
          end
          if (mem_rvalid && load_q) rv_q <= 1'b1;
          d0_q <= d0_n;
          d1_q <= d1_n;
          if (beat_done) begin
            {rdy_q, rv_q} <= '0;
            if (state == BEAT0 && split_q) begin
              state <= BEAT1;
              mem_valid <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(NB);
              mem_be <= be1_q;
              mem_wdata <= wd1_q;
            end else begin
              state <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_q ? ext : '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: directed checks of alignment, splitting, faults, wait states and reset abort
module tb_mem_align_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_valid2 = 1'b0, req_load = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic mem_ready = 1'b1, mem_rvalid = 1'b1;
  logic [31:0] mem_rdata = '0;
  logic req_ready, rsp_valid, rsp_fault, mem_valid, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic req_ready2, rsp_valid2, rsp_fault2, mem_valid2, mem_we2;
  logic [31:0] rsp_rdata2, mem_addr2, mem_wdata2;
  logic [3:0] mem_be2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_align_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_align_unit #(.SPLIT_MISALIGNED(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_load(req_load), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_fault(rsp_fault2),
    .mem_valid(mem_valid2), .mem_ready(mem_ready), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_be(mem_be2), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_load = ld;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_chk++;
    if ({req_ready, rsp_valid, rsp_fault, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata, req_ready2, mem_valid2}
        !== {1'b1, 4'b0, 4'b0, 96'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: ready=%b rv=%b f=%b mv=%b we=%b be=%b a=%h wd=%h rd=%h, required ready=1 all else 0",
               req_ready, rsp_valid, rsp_fault, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_byte_load(input logic [2:0] f3, input logic [31:0] exp);
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h80123456;
    issue(1'b1, f3, 32'h1003, 32'h0);
    n_chk++;
    if ({mem_valid, mem_we, mem_addr, mem_be, rsp_valid} !== {1'b1, 1'b0, 32'h1000, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL byte_beat0 f3=%b: mv=%b we=%b a=%h be=%b rv=%b, required 1 0 00001000 1000 0",
               f3, mem_valid, mem_we, mem_addr, mem_be, rsp_valid);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, 1'b0, exp}) begin
      n_fail++;
      $display("FAIL byte_rsp f3=%b: rv=%b f=%b rd=%h, required 1 0 %h", f3, rsp_valid, rsp_fault, rsp_rdata, exp);
    end
    step();
    n_chk++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL byte_idle f3=%b: rv=%b ready=%b, required 0 1", f3, rsp_valid, req_ready);
    end
  endtask

  task automatic test_split_store();
    mem_ready = 1'b1;
    issue(1'b0, 3'b010, 32'h2002, 32'hAABBCCDD);
    n_chk++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 4'b1100, 32'hCCDD0000}) begin
      n_fail++;
      $display("FAIL sw_beat0: mv=%b we=%b a=%h be=%b wd=%h, required 1 1 00002000 1100 ccdd0000",
               mem_valid, mem_we, mem_addr, mem_be, mem_wdata);
    end
    step();
    n_chk++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid} !== {1'b1, 1'b1, 32'h2004, 4'b0011, 32'h0000AABB, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_beat1: mv=%b we=%b a=%h be=%b wd=%h rv=%b, required 1 1 00002004 0011 0000aabb 0",
               mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_fault, rsp_rdata, mem_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_rsp: rv=%b f=%b rd=%h mv=%b, required 1 0 00000000 0", rsp_valid, rsp_fault, rsp_rdata, mem_valid);
    end
    step();
  endtask

  task automatic test_wrap_half();
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0);
    mem_rdata = 32'h34000000;
    n_chk++;
    if ({mem_valid, mem_addr, mem_be} !== {1'b1, 32'hFFFFFFFC, 4'b1000}) begin
      n_fail++;
      $display("FAIL lh_wrap_beat0: mv=%b a=%h be=%b, required 1 fffffffc 1000", mem_valid, mem_addr, mem_be);
    end
    step();
    mem_rdata = 32'hDEADBE12;
    n_chk++;
    if ({mem_valid, mem_addr, mem_be} !== {1'b1, 32'h00000000, 4'b0001}) begin
      n_fail++;
      $display("FAIL lh_wrap_beat1: mv=%b a=%h be=%b, required 1 00000000 0001", mem_valid, mem_addr, mem_be);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, 1'b0, 32'h00001234}) begin
      n_fail++;
      $display("FAIL lh_wrap_rsp: rv=%b f=%b rd=%h, required 1 0 00001234", rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [3:0] cases [3] = '{4'b1_011, 4'b0_100, 4'b1_111};
    for (int i = 0; i < 3; i++) begin
      issue(cases[i][3], cases[i][2:0], 32'h1000, 32'hFFFFFFFF);
      n_chk++;
      if ({rsp_valid, rsp_fault, rsp_rdata, mem_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL illegal_rsp ld/f3=%b: rv=%b f=%b rd=%h mv=%b, required 1 1 00000000 0",
                 cases[i], rsp_valid, rsp_fault, rsp_rdata, mem_valid);
      end
      step();
      n_chk++;
      if ({rsp_valid, rsp_fault, mem_valid, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL illegal_idle ld/f3=%b: rv=%b f=%b mv=%b ready=%b, required 0 0 0 1",
                 cases[i], rsp_valid, rsp_fault, mem_valid, req_ready);
      end
    end
  endtask

  task automatic test_nosplit_fault();
    req_valid2 = 1'b1;
    req_load = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h1001;
    step();
    req_valid2 = 1'b0;
    n_chk++;
    if ({rsp_valid2, rsp_fault2, rsp_rdata2, mem_valid2} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL nosplit_rsp: rv=%b f=%b rd=%h mv=%b, required 1 1 00000000 0", rsp_valid2, rsp_fault2, rsp_rdata2, mem_valid2);
    end
    step();
    n_chk++;
    if ({rsp_valid2, mem_valid2, req_ready2, mem_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL nosplit_idle: rv=%b mv=%b ready=%b main_mv=%b, required 0 0 1 0", rsp_valid2, mem_valid2, req_ready2, mem_valid);
    end
  endtask

  task automatic test_wait_states();
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    issue(1'b1, 3'b010, 32'h3000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({mem_valid, mem_we, mem_addr, mem_be, rsp_valid} !== {1'b1, 1'b0, 32'h3000, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_hold cyc%0d: mv=%b we=%b a=%h be=%b rv=%b, required 1 0 00003000 1111 0",
                 i, mem_valid, mem_we, mem_addr, mem_be, rsp_valid);
      end
      step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_chk++;
    if ({mem_valid, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_after_ready: mv=%b rv=%b, required 0 0", mem_valid, rsp_valid);
    end
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h12345678;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_no_early_rsp: rv=%b, required 0", rsp_valid);
    end
    step();
    mem_rvalid = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      n_fail++;
      $display("FAIL wait_rsp: rv=%b f=%b rd=%h, required 1 0 12345678", rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
  endtask

  task automatic test_reset_mid();
    mem_rdata = 32'hCAFEF00D;
    issue(1'b1, 3'b010, 32'h4002, 32'h0);
    step();
    n_chk++;
    if ({mem_valid, mem_addr} !== {1'b1, 32'h4004}) begin
      n_fail++;
      $display("FAIL rstmid_beat1: mv=%b a=%h, required 1 00004004", mem_valid, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_valid, req_ready, rsp_valid, mem_be, mem_addr} !== {1'b0, 1'b1, 1'b0, 4'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstmid_async: mv=%b ready=%b rv=%b be=%b a=%h, required 0 1 0 0000 00000000",
               mem_valid, req_ready, rsp_valid, mem_be, mem_addr);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({rsp_valid, mem_valid, req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL rstmid_quiet cyc%0d: rv=%b mv=%b ready=%b, required 0 0 1", i, rsp_valid, mem_valid, req_ready);
      end
    end
    test_byte_load(3'b100, 32'h00000080);
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h80123456;
    issue(1'b0, 3'b010, 32'h5000, 32'h11223344);
    req_valid = 1'b1;
    req_load = 1'b1;
    req_funct3 = 3'b100;
    req_addr = 32'h1003;
    n_chk++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata, req_ready} !== {1'b1, 1'b1, 32'h5000, 4'b1111, 32'h11223344, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_store_beat: mv=%b we=%b a=%h be=%b wd=%h ready=%b, required 1 1 00005000 1111 11223344 0",
               mem_valid, mem_we, mem_addr, mem_be, mem_wdata, req_ready);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_rdata, req_ready} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_store_rsp: rv=%b rd=%h ready=%b, required 1 00000000 0", rsp_valid, rsp_rdata, req_ready);
    end
    step();
    n_chk++;
    if ({rsp_valid, mem_valid, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_idle: rv=%b mv=%b ready=%b, required 0 0 1", rsp_valid, mem_valid, req_ready);
    end
    step();
    req_valid = 1'b0;
    n_chk++;
    if ({mem_valid, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h1000, 4'b1000}) begin
      n_fail++;
      $display("FAIL b2b_load_beat: mv=%b we=%b a=%h be=%b, required 1 0 00001000 1000", mem_valid, mem_we, mem_addr, mem_be);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h00000080}) begin
      n_fail++;
      $display("FAIL b2b_load_rsp: rv=%b rd=%h, required 1 00000080", rsp_valid, rsp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_byte_load(3'b000, 32'hFFFFFF80);
    test_byte_load(3'b100, 32'h00000080);
    test_split_store();
    test_wrap_half();
    test_illegal();
    test_nosplit_fault();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_align_unit.md
MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter SPLIT_MISALIGNED, default 1; 1 = split a misaligned access into two beats, 0 = fault it.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1 / 1  CPU request handshake.
- req_load  in  1  1 = load, 0 = store.
- req_funct3  in  3  RISC-V funct3; size = [1:0], unsigned = [2].
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data.
- rsp_fault  out  1  qualifies rsp_valid: illegal or misaligned access.
- mem_valid / mem_ready  out / in  1 / 1  memory beat handshake.
- mem_we  out  1  write beat.
- mem_addr  out  ADDR_W  XLEN/8-aligned word address.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_be  out  XLEN/8  byte enables.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.

Function
REQ-005 FSM states SHALL be IDLE, BEAT0, BEAT1, RESP; req_ready = (state == IDLE).
REQ-006 Accept on req_valid && req_ready; latch load, funct3, addr and wdata; the request is captured at the accept edge.
REQ-007 Size SHALL be 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11.
REQ-008 Illegal cases SHALL go IDLE->RESP with rsp_fault=1, rsp_rdata=0 and no mem_valid:
- funct3 = 111.
- funct3[1:0] = 11 when XLEN = 32.
- funct3 = 110 when XLEN = 32.
- store with funct3[2] = 1.
REQ-009 offset = addr mod XLEN/8; misaligned when offset+size > XLEN/8.
REQ-010 A misaligned access with SPLIT_MISALIGNED=0 SHALL fault exactly as REQ-008.
REQ-011 BEAT0 SHALL drive mem_addr = addr with low log2(XLEN/8) bits cleared, mem_be = size-mask << offset (truncated to XLEN/8 bits), mem_wdata = wdata << 8*offset.
REQ-012 For a split access, BEAT1 SHALL drive mem_addr = BEAT0 address + XLEN/8 (modulo 2^ADDR_W, wrap legal), the remaining byte enables, and the remaining wdata bytes in the low lanes.
REQ-013 mem_valid, mem_addr, mem_we, mem_be and mem_wdata SHALL hold stable until mem_ready.
REQ-014 A store beat completes on mem_ready.
REQ-015 A load beat completes when both mem_ready and mem_rvalid have been seen; they may coincide or mem_rvalid may follow mem_ready later.
REQ-016 Load data SHALL be assembled from the beat-0 upper lanes and beat-1 lower lanes, then sign-extended (funct3[2]=0) or zero-extended to XLEN.
- funct3 = 010 with XLEN = 32 returns the full word.
- funct3 = 110 with XLEN = 64 zero-extends the word.
REQ-017 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata = 0 for stores; no response backpressure.
REQ-018 Latency with zero-wait memory SHALL be: accept at T, BEAT0 at T+1, rsp_valid at T+2 (aligned) or T+3 (split).
REQ-019 req_valid SHALL be ignored outside IDLE; back-to-back requests are accepted in the cycle after RESP.

Reset
REQ-020 rst_n low SHALL force IDLE asynchronously, from any state including mid-beat.
REQ-021 During and after reset: req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-022 Partially assembled load data SHALL be discarded on reset, and no response SHALL be issued for the aborted request.

Structure
REQ-023 lib_pkg SHALL hold the funct3 size/unsigned encodings and the FSM state enum type.
REQ-024 Lane extraction plus sign/zero extension SHALL be a combinational sub-module mem_lane_extend, parametrised by XLEN.

Verification
REQ-025 XLEN=32, zero-wait memory:
- LB at 0x1003 with mem_rdata 0x80xxxxxx -> BEAT0 be=1000, rsp_rdata 0xFFFFFF80 at T+2.
- LBU at the same address and data -> rsp_rdata 0x00000080.
REQ-026 XLEN=32: SW 0xAABBCCDD at 0x2002 -> two beats:
- beat 0: 0x2000, be=1100, wdata 0xCCDD0000.
- beat 1: 0x2004, be=0011, wdata 0x0000AABB.
- rsp_valid at T+3.
REQ-027 XLEN=32: LH at 0xFFFFFFFF -> beat 1 addr 0x00000000; beat-0 byte 0x34 and beat-1 byte 0x12 -> rsp_rdata 0x00001234.
REQ-028 Illegal or faulting requests -> rsp_fault=1 at T+1, mem_valid never asserted:
- XLEN=32, funct3=011.
- XLEN=32, SPLIT_MISALIGNED=0, LW at 0x1001.
REQ-029 mem_ready held low 5 cycles on a load -> request signals stable throughout; mem_rvalid 2 cycles after mem_ready -> response follows it.
REQ-030 rst_n pulsed low during BEAT1 -> mem_valid=0 immediately, IDLE, no rsp_valid; the next request completes normally.
